// File: rtl/uart_recv_bytes.sv
// ----------------------------------------------------------------------------
// uart_recv_bytes
// Multi-byte UART receive assembler. It sits behind the byte-level UART
// receiver and collects BYTES_NUM consecutive bytes, MSB byte first, into one
// DATA_W-bit word. Each completed word is presented on bytes_dr together with
// a one-cycle bytes_done strobe.
//
// Optional feature macro: UART_RECV_BYTES_TIMEOUT_EN
//   defined   : an inter-byte timeout of TIMEOUT_CYC idle cycles drops a
//               partial word and pulses bytes_err for one cycle.
//   undefined : no timeout logic, bytes_err is tied low, and a partial word
//               waits indefinitely for its remaining bytes.
// ----------------------------------------------------------------------------
module uart_recv_bytes #(
  parameter int BYTES_NUM   = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              CLK_SYS,
  input  logic              CLK_RST,
  input  logic              uart_done,
  input  logic [7:0]        uart_data,
  output logic              bytes_busy,
  output logic              bytes_done,
  output logic [DATA_W-1:0] bytes_dr,
  output logic              bytes_err
);

  // Byte counter must be able to hold BYTES_NUM for the single DONE cycle.
  localparam int CNT_W = $clog2(BYTES_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_NUM - 1);

  // Reject configurations the shift register and counters cannot represent.
  if ((DATA_W != BYTES_NUM * 8) || (BYTES_NUM < 2) || (BYTES_NUM > 8) ||
      (TIMEOUT_CYC < 2)) begin : g_bad_params
    $error("uart_recv_bytes: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shift_reg;
  logic               done_d0;
  logic               done_d1;
  logic [7:0]         data_d0;
  logic               byte_flag;

  // A uart_done held high for many cycles still yields a single byte_flag.
  assign byte_flag = done_d0 & ~done_d1;

`ifdef UART_RECV_BYTES_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_expire;

  assign to_expire = (to_cnt == TO_LAST);

  // Inter-byte idle counter: runs only while a word is partially received.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      to_cnt <= '0;
    end else if (byte_flag || (state != RECV)) begin
      to_cnt <= '0;
    end else if (!to_expire) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign bytes_err = 1'b0;
`endif

  // Synchronise the byte strobe and capture the byte alongside it.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      done_d0 <= 1'b0;
      done_d1 <= 1'b0;
      data_d0 <= 8'h00;
    end else begin
      done_d0 <= uart_done;
      done_d1 <= done_d0;
      data_d0 <= uart_data;
    end
  end

  // Word assembly FSM with registered busy/done/err outputs.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      bytes_busy <= 1'b0;
      bytes_done <= 1'b0;
      bytes_dr   <= '0;
`ifdef UART_RECV_BYTES_TIMEOUT_EN
      bytes_err  <= 1'b0;
`endif
    end else begin
      bytes_done <= 1'b0;
`ifdef UART_RECV_BYTES_TIMEOUT_EN
      bytes_err  <= 1'b0;
`endif
      if (byte_flag) begin
        shift_reg <= {shift_reg[DATA_W-9:0], data_d0};
      end

      case (state)
        IDLE: begin
          if (byte_flag) begin
            state      <= RECV;
            cnt        <= CNT_W'(1);
            bytes_busy <= 1'b1;
          end
        end

        RECV: begin
          if (byte_flag) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= DONE;
            end
          end
`ifdef UART_RECV_BYTES_TIMEOUT_EN
          else if (to_expire) begin
            state      <= IDLE;
            cnt        <= '0;
            bytes_busy <= 1'b0;
            bytes_err  <= 1'b1;
          end
`endif
        end

        DONE: begin
          // The completed word leaves here; a byte arriving now opens the
          // next word without being lost.
          bytes_dr   <= shift_reg;
          bytes_done <= 1'b1;
          if (byte_flag) begin
            state      <= RECV;
            cnt        <= CNT_W'(1);
            bytes_busy <= 1'b1;
          end else begin
            state      <= IDLE;
            cnt        <= '0;
            bytes_busy <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          cnt        <= '0;
          bytes_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv_bytes.sv
// ----------------------------------------------------------------------------
// tb_uart_recv_bytes
// Self-checking bench for uart_recv_bytes. Expected words are pushed to a
// scoreboard when the last byte of a word is driven; a monitor pops and
// compares them (value and 3-cycle latency) whenever bytes_done is seen.
// Timeout scenarios are built only when UART_RECV_BYTES_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_uart_recv_bytes;

  localparam int BYTES_NUM   = 4;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 40;

  logic              CLK_SYS = 1'b0;
  logic              CLK_RST = 1'b1;
  logic              uart_done = 1'b0;
  logic [7:0]        uart_data = 8'h00;
  logic              bytes_busy;
  logic              bytes_done;
  logic [DATA_W-1:0] bytes_dr;
  logic              bytes_err;

  uart_recv_bytes #(
    .BYTES_NUM  (BYTES_NUM),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK_SYS   (CLK_SYS),
    .CLK_RST   (CLK_RST),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .bytes_busy(bytes_busy),
    .bytes_done(bytes_done),
    .bytes_dr  (bytes_dr),
    .bytes_err (bytes_err)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] seq;
    int          hold;
    int          gap;
    logic [31:0] word;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rise = 0;
  int          err_seen = 0;
  int          err_cyc = 0;
  int          exp_err = 0;
  logic [31:0] last_dr = '0;

  // Posedge counter used for latency bookkeeping; stable at negedges.
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on done, hold check otherwise, count errors.
  always @(negedge CLK_SYS) begin
    if (!CLK_RST) begin
      last_dr = '0;
    end else begin
      if (bytes_done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", {32'h0, bytes_dr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("word", {32'h0, bytes_dr}, {32'h0, e.word});
          checkOutput("latency", cyc, e.due);
        end
      end else begin
        checkOutput("dr_stable", {32'h0, bytes_dr}, {32'h0, last_dr});
      end
      last_dr = bytes_dr;
      if (bytes_err) begin
        err_seen++;
        err_cyc = cyc;
      end
    end
  end

  // Drive one byte: rise, hold for 'hold' cycles, then idle so that the next
  // rise comes hold+gap cycles after this one.
  task automatic sendByte(input logic [7:0] b, input int hold, input int gap,
                          input logic push, input logic [31:0] word);
    @(negedge CLK_SYS);
    uart_done = 1'b1;
    uart_data = b;
    last_rise = cyc;
    if (push) sb.push_back('{word, cyc + 3});
    repeat (hold) @(negedge CLK_SYS);
    uart_done = 1'b0;
    uart_data = ~b;
    repeat (gap - 1) @(negedge CLK_SYS);
  endtask

  task automatic applyStimulus(input logic [31:0] seq, input int hold,
                               input int gap, input logic [31:0] word);
    for (int i = 0; i < BYTES_NUM; i++) begin
      logic [7:0] b;
      b = seq[31 - 8*i -: 8];
      sendByte(b, hold, gap, (i == BYTES_NUM - 1), word);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge CLK_SYS);
    end
    repeat (2) @(negedge CLK_SYS);
    checkOutput("drain", sb.size(), 0);
  endtask

  initial begin
    int err_before;

    vecs[0] = '{32'h12345678, 10, 5, 32'h12345678};
    vecs[1] = '{32'hA55AFF00, 20, 3, 32'hA55AFF00};
    vecs[2] = '{32'h80000001,  2, 2, 32'h80000001};
    vecs[3] = '{32'hFFFFFFFF,  1, 4, 32'hFFFFFFFF};
    vecs[4] = '{32'h01020304,  1, 1, 32'h01020304};
    vecs[5] = '{32'h05060708,  1, 1, 32'h05060708};

    #2 CLK_RST = 1'b0;
    repeat (3) @(negedge CLK_SYS);
    checkOutput("rst_busy", bytes_busy, 0);
    checkOutput("rst_done", bytes_done, 0);
    checkOutput("rst_dr",   bytes_dr,   0);
    checkOutput("rst_err",  bytes_err,  0);
    CLK_RST = 1'b1;
    repeat (2) @(negedge CLK_SYS);

    // Pulse widths, long holds, and back-to-back words (last two entries).
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].seq, vecs[v].hold, vecs[v].gap, vecs[v].word);
    end
    waitDrain();
    checkOutput("idle_busy", bytes_busy, 0);

`ifdef UART_RECV_BYTES_TIMEOUT_EN
    // Partial word dropped after the idle timeout.
    sendByte(8'h11, 3, 3, 1'b0, 32'h0);
    checkOutput("partial_busy", bytes_busy, 1);
    sendByte(8'h22, 3, 1, 1'b0, 32'h0);
    err_before = err_seen;
    for (int i = 0; i < TIMEOUT_CYC + 20; i++) begin
      if (err_seen != err_before) break;
      @(negedge CLK_SYS);
    end
    exp_err++;
    checkOutput("timeout_err", err_seen, err_before + 1);
    checkOutput("timeout_cyc", err_cyc, last_rise + 2 + TIMEOUT_CYC);
    @(negedge CLK_SYS);
    checkOutput("timeout_busy", bytes_busy, 0);
    checkOutput("timeout_dr", bytes_dr, 32'h05060708);
    applyStimulus(32'hDEADBEEF, 2, 3, 32'hDEADBEEF);
    waitDrain();

    // Each next byte lands exactly on the expiry cycle: the byte wins.
    err_before = err_seen;
    applyStimulus(32'hC0FFEE01, 3, TIMEOUT_CYC - 3, 32'hC0FFEE01);
    waitDrain();
    checkOutput("coincident_no_err", err_seen, err_before);
`else
    // Without the timeout a partial word waits and is later completed.
    sendByte(8'h11, 3, 3, 1'b0, 32'h0);
    sendByte(8'h22, 3, 3, 1'b0, 32'h0);
    repeat (200) @(negedge CLK_SYS);
    checkOutput("wait_busy", bytes_busy, 1);
    sendByte(8'h33, 3, 3, 1'b0, 32'h0);
    sendByte(8'h44, 3, 3, 1'b1, 32'h11223344);
    waitDrain();
`endif

    // Reset in the middle of a word discards it and clears bytes_dr.
    sendByte(8'hAB, 2, 3, 1'b0, 32'h0);
    sendByte(8'hCD, 2, 3, 1'b0, 32'h0);
    checkOutput("mid_busy", bytes_busy, 1);
    @(negedge CLK_SYS);
    CLK_RST = 1'b0;
    repeat (2) @(negedge CLK_SYS);
    checkOutput("mid_rst_busy", bytes_busy, 0);
    checkOutput("mid_rst_done", bytes_done, 0);
    checkOutput("mid_rst_dr",   bytes_dr,   0);
    checkOutput("mid_rst_err",  bytes_err,  0);
    CLK_RST = 1'b1;
    repeat (2) @(negedge CLK_SYS);
    applyStimulus(32'hCAFEBABE, 4, 4, 32'hCAFEBABE);
    waitDrain();

    checkOutput("err_count", err_seen, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
